// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor snapshot sequencer:
// sensor-manager register offsets, AHB-Lite encodings and the sequencer state type.
package sensor_pkg;

    localparam logic [31:0] SNS_OFS_FORK   = 32'h0000_0000;
    localparam logic [31:0] SNS_OFS_DCRANK = 32'h0000_0004;
    localparam logic [31:0] SNS_OFS_DFORK  = 32'h0000_0008;
    localparam logic [31:0] SNS_OFS_CTIME  = 32'h0000_000C;
    localparam logic [31:0] SNS_OFS_FTIME  = 32'h0000_0010;

    localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
    localparam logic [2:0]  HSIZE_WORD     = 3'b010;

    // Index of the last register in the read sequence (0x10)
    localparam logic [2:0]  LAST_IDX       = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Register offset for a position in the fixed read order
    function automatic logic [31:0] sns_offset(input logic [2:0] idx);
        logic [31:0] ofs;
        case (idx)
            3'd0:    ofs = SNS_OFS_FORK;
            3'd1:    ofs = SNS_OFS_DCRANK;
            3'd2:    ofs = SNS_OFS_DFORK;
            3'd3:    ofs = SNS_OFS_CTIME;
            3'd4:    ofs = SNS_OFS_FTIME;
            default: ofs = SNS_OFS_FORK;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1 and flags the wrap cycle.
module ms_tick_gen #(
    parameter int CLKS_PER_MS = 33
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_ms_tick
);

    localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    // Free-running prescaler, restarts at zero after the last count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_ms_tick = (r_cnt == LAST);

endmodule

// File: rtl/sensor_snapshot_sequencer.sv
// AHB-Lite master that reads the five sensor-manager registers in fixed order
// (0x00, 0x04, 0x08, 0x0C, 0x10) on a periodic or one-shot trigger and
// presents them as one coherent snapshot.
// Optional feature macro: SNAPSHOT_IRQ_EN (sticky completion interrupt).
module sensor_snapshot_sequencer
    import sensor_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
    parameter int          CLKS_PER_MS = 33,
    parameter int          PERIOD_W    = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_ms,
    input  logic                start,
    output logic [31:0]         M_HADDR,
    output logic [1:0]          M_HTRANS,
    output logic                M_HWRITE,
    output logic [2:0]          M_HSIZE,
    output logic [31:0]         M_HWDATA,
    input  logic [31:0]         M_HRDATA,
    input  logic                M_HREADY,
    output logic [15:0]         snap_fork,
    output logic [7:0]          snap_dcrank,
    output logic [7:0]          snap_dfork,
    output logic [15:0]         snap_ctime,
    output logic [15:0]         snap_ftime,
    output logic                snap_valid,
    output logic                busy,
    output logic                overrun,
    output logic                irq,
    input  logic                irq_clear
);

    logic                w_ms_tick;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic                r_period_trig;
    logic [PERIOD_W-1:0] w_period_inc;
    logic                w_trigger;

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;

    logic [31:0]         w_haddr_nxt;
    logic [1:0]          w_htrans_nxt;
    logic                w_busy_nxt;
    logic                w_valid_nxt;
    logic                w_capture;
    logic                w_ovr_set;

    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_ms_tick_gen (
        .i_clk     (HCLK),
        .i_rst     (HRESET),
        .o_ms_tick (w_ms_tick)
    );

    assign w_period_inc = r_period_cnt + {{(PERIOD_W-1){1'b0}}, 1'b1};
    assign w_trigger    = r_period_trig | start;

    // Period counter: counts ms ticks and pulses a trigger when period_ms is reached
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_period_cnt  <= {PERIOD_W{1'b0}};
            r_period_trig <= 1'b0;
        end else if (!enable || (period_ms == {PERIOD_W{1'b0}})) begin
            r_period_cnt  <= {PERIOD_W{1'b0}};
            r_period_trig <= 1'b0;
        end else if (w_ms_tick) begin
            // >= so a shortened period takes effect without a counter wrap
            if (w_period_inc >= period_ms) begin
                r_period_cnt  <= {PERIOD_W{1'b0}};
                r_period_trig <= 1'b1;
            end else begin
                r_period_cnt  <= w_period_inc;
                r_period_trig <= 1'b0;
            end
        end else begin
            r_period_cnt  <= r_period_cnt;
            r_period_trig <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: one non-pipelined read per register, wait states stall in place
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = ADDR;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ADDR: begin
                if (M_HREADY) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = ADDR;
                end
            end
            DATA: begin
                if (!M_HREADY) begin
                    w_state_nxt = DATA;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ADDR;
                    w_idx_nxt   = r_idx + 3'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so bus outputs can be registered without lag
    always_comb begin
        w_htrans_nxt = HTRANS_IDLE;
        w_haddr_nxt  = 32'h0000_0000;
        if (w_state_nxt == ADDR) begin
            w_htrans_nxt = HTRANS_NONSEQ;
            w_haddr_nxt  = BASE_ADDR + sns_offset(w_idx_nxt);
        end else begin
            w_htrans_nxt = HTRANS_IDLE;
            w_haddr_nxt  = 32'h0000_0000;
        end
        w_busy_nxt  = (w_state_nxt == ADDR) || (w_state_nxt == DATA);
        w_valid_nxt = (w_state_nxt == DONE);
        w_capture   = (r_state == DATA) && M_HREADY;
        w_ovr_set   = w_trigger && (r_state != IDLE);
    end

    // Registered bus outputs, status and snapshot captures
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            M_HADDR     <= 32'h0000_0000;
            M_HTRANS    <= HTRANS_IDLE;
            busy        <= 1'b0;
            snap_valid  <= 1'b0;
            overrun     <= 1'b0;
            snap_fork   <= 16'h0000;
            snap_dcrank <= 8'h00;
            snap_dfork  <= 8'h00;
            snap_ctime  <= 16'h0000;
            snap_ftime  <= 16'h0000;
        end else begin
            M_HADDR    <= w_haddr_nxt;
            M_HTRANS   <= w_htrans_nxt;
            busy       <= w_busy_nxt;
            snap_valid <= w_valid_nxt;
            // A clear drops the old flag; a trigger in the same cycle still sets it anew
            if (irq_clear) begin
                overrun <= w_ovr_set;
            end else begin
                overrun <= overrun | w_ovr_set;
            end
            if (w_capture) begin
                case (r_idx)
                    3'd0:    snap_fork   <= M_HRDATA[15:0];
                    3'd1:    snap_dcrank <= M_HRDATA[7:0];
                    3'd2:    snap_dfork  <= M_HRDATA[7:0];
                    3'd3:    snap_ctime  <= M_HRDATA[15:0];
                    3'd4:    snap_ftime  <= M_HRDATA[15:0];
                    default: snap_fork   <= snap_fork;
                endcase
            end else begin
                snap_fork <= snap_fork;
            end
        end
    end

`ifdef SNAPSHOT_IRQ_EN
    logic r_irq;

    // Sticky completion interrupt; clear wins over a simultaneous set
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_irq <= 1'b0;
        end else if (irq_clear) begin
            r_irq <= 1'b0;
        end else if (w_valid_nxt) begin
            r_irq <= 1'b1;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign M_HWRITE = 1'b0;
    assign M_HSIZE  = HSIZE_WORD;
    assign M_HWDATA = 32'h0000_0000;

endmodule

// File: tb/tb_sensor_snapshot_sequencer.sv
// Self-checking bench for sensor_snapshot_sequencer: table vectors, randomized
// sequences against a snapshot model, periodic-trigger timing and reset abort.
module tb_sensor_snapshot_sequencer;

    logic        HCLK;
    logic        HRESET;
    logic        enable;
    logic [15:0] period_ms;
    logic        start;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;
    logic [15:0] snap_fork;
    logic [7:0]  snap_dcrank;
    logic [7:0]  snap_dfork;
    logic [15:0] snap_ctime;
    logic [15:0] snap_ftime;
    logic        snap_valid;
    logic        busy;
    logic        overrun;
    logic        irq;
    logic        irq_clear;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0][31:0] data;    // slave read data, element i = offset 4*i
        logic [4:0][3:0]  wa;      // wait states in address phase
        logic [4:0][3:0]  wd;      // wait states in data phase
        int               ovr_at;  // cycle with start pulse while busy (-1 none)
        int               clr_at;  // cycle with irq_clear (-1 none)
        logic [4:0][31:0] e_snap;  // expected snapshot fields, zero-extended
        logic             e_ovr;   // expected overrun after the sequence
    } vec_t;

    vec_t             tbl[7];
    logic [4:0][31:0] last_snap;
    logic             m_ovr;

    sensor_snapshot_sequencer dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .enable      (enable),
        .period_ms   (period_ms),
        .start       (start),
        .M_HADDR     (M_HADDR),
        .M_HTRANS    (M_HTRANS),
        .M_HWRITE    (M_HWRITE),
        .M_HSIZE     (M_HSIZE),
        .M_HWDATA    (M_HWDATA),
        .M_HRDATA    (M_HRDATA),
        .M_HREADY    (M_HREADY),
        .snap_fork   (snap_fork),
        .snap_dcrank (snap_dcrank),
        .snap_dfork  (snap_dfork),
        .snap_ctime  (snap_ctime),
        .snap_ftime  (snap_ftime),
        .snap_valid  (snap_valid),
        .busy        (busy),
        .overrun     (overrun),
        .irq         (irq),
        .irq_clear   (irq_clear)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_snap(input int i);
        case (i)
            0:       return {16'h0000, snap_fork};
            1:       return {24'h000000, snap_dcrank};
            2:       return {24'h000000, snap_dfork};
            3:       return {16'h0000, snap_ctime};
            4:       return {16'h0000, snap_ftime};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Register widths: fork/ctime/ftime keep 16 bits, the delta counts keep 8
    function automatic logic [31:0] trunc(input int i, input logic [31:0] d);
        if (i == 1 || i == 2) return d & 32'h0000_00FF;
        else                  return d & 32'h0000_FFFF;
    endfunction

    // Acts as the sensor-manager slave for one start-triggered sequence
    task automatic run_seq(input vec_t v, input string tag);
        int cyc;
        @(negedge HCLK);
        start = 1'b1; M_HREADY = 1'b1; irq_clear = 1'b0;
        @(negedge HCLK);
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w <= int'(v.wa[i]); w++) begin
                chk({tag, "_addr_htrans"}, 32'(M_HTRANS), 32'h2);
                chk({tag, "_addr_haddr"}, M_HADDR, 32'h6000_0000 + 32'(4 * i));
                chk({tag, "_busy"}, 32'(busy), 32'h1);
                chk({tag, "_early_valid"}, 32'(snap_valid), 32'h0);
                start     = (cyc == v.ovr_at);
                irq_clear = (cyc == v.clr_at);
                M_HREADY  = (w == int'(v.wa[i]));
                M_HRDATA  = 32'hBAD0_0000;
                @(negedge HCLK);
                cyc++;
            end
            for (int w = 0; w <= int'(v.wd[i]); w++) begin
                chk({tag, "_data_htrans"}, 32'(M_HTRANS), 32'h0);
                chk({tag, "_snap_hold"}, dut_snap(i), last_snap[i]);
                chk({tag, "_early_valid"}, 32'(snap_valid), 32'h0);
                start     = (cyc == v.ovr_at);
                irq_clear = (cyc == v.clr_at);
                M_HREADY  = (w == int'(v.wd[i]));
                M_HRDATA  = M_HREADY ? v.data[i] : (32'hBAD0_0000 | 32'(w));
                @(negedge HCLK);
                cyc++;
            end
        end
        start = 1'b0; irq_clear = 1'b0; M_HREADY = 1'b1;
        chk({tag, "_snap_valid"}, 32'(snap_valid), 32'h1);
        chk({tag, "_busy_done"}, 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) chk({tag, "_snap"}, dut_snap(i), v.e_snap[i]);
        chk({tag, "_overrun"}, 32'(overrun), 32'(v.e_ovr));
`ifdef SNAPSHOT_IRQ_EN
        if (v.clr_at < 0) chk({tag, "_irq"}, 32'(irq), 32'h1);
`else
        chk({tag, "_irq"}, 32'(irq), 32'h0);
`endif
        @(negedge HCLK);
        chk({tag, "_valid_pulse"}, 32'(snap_valid), 32'h0);
        last_snap = v.e_snap;
        m_ovr     = v.e_ovr;
    endtask

    initial begin
        int   rises[$];
        logic pb;
        int   cnt;
        vec_t rv;

        HRESET = 1'b1; enable = 1'b0; period_ms = 16'd0; start = 1'b0;
        M_HRDATA = 32'h0; M_HREADY = 1'b1; irq_clear = 1'b0;
        last_snap = '0; m_ovr = 1'b0;

        // Table: {data(idx4..idx0), addr waits, data waits, ovr_at, clr_at, expected snap, expected overrun}
        tbl[0] = '{{32'h55, 32'h44, 32'h33, 32'h22, 32'h11}, '0, '0, -1, -1,
                   {32'h55, 32'h44, 32'h33, 32'h22, 32'h11}, 1'b0};
        tbl[1] = '{{32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1}, '0,
                   {4'd0, 4'd0, 4'd3, 4'd0, 4'd0}, -1, -1,
                   {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0};
        tbl[2] = '{{32'hCAFE_0001, 32'h0BAD_F00D, 32'hFFFF_FF7E, 32'h1234_56C3, 32'hDEAD_BEEF},
                   {4'd1, 4'd0, 4'd2, 4'd0, 4'd1}, {4'd0, 4'd1, 4'd0, 4'd2, 4'd0}, 5, -1,
                   {32'h0001, 32'hF00D, 32'h7E, 32'hC3, 32'hBEEF}, 1'b1};
        tbl[3] = '{{32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, '0, '0, -1, -1,
                   {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 1'b1};
        tbl[4] = '{{32'hFFFF_FFFF, 32'h8000_8000, 32'h0000_0100, 32'h0000_01FF, 32'h0001_0000},
                   '0, '0, -1, 3,
                   {32'hFFFF, 32'h8000, 32'h00, 32'hFF, 32'h0000}, 1'b0};
        tbl[5] = '{{32'h9, 32'h8, 32'h7, 32'h6, 32'h5}, '0, '0, 4, 4,
                   {32'h9, 32'h8, 32'h7, 32'h6, 32'h5}, 1'b1};
        tbl[6] = '{{32'h19, 32'h18, 32'h17, 32'h16, 32'h15}, '0, '0, -1, 2,
                   {32'h19, 32'h18, 32'h17, 32'h16, 32'h15}, 1'b0};

        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        chk("rst_htrans", 32'(M_HTRANS), 32'h0);
        chk("rst_haddr", M_HADDR, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(snap_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_hsize", 32'(M_HSIZE), 32'h2);
        chk("rst_hwrite", 32'(M_HWRITE), 32'h0);
        chk("rst_hwdata", M_HWDATA, 32'h0);
        for (int i = 0; i < 5; i++) chk("rst_snap", dut_snap(i), 32'h0);

        for (int t = 0; t < 7; t++) run_seq(tbl[t], "tbl");

        // Randomized sequences against the snapshot/overrun model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 5; i++) begin
                rv.data[i]   = $urandom;
                rv.wa[i]     = 4'($urandom_range(0, 3));
                rv.wd[i]     = 4'($urandom_range(0, 3));
                rv.e_snap[i] = trunc(i, rv.data[i]);
            end
            rv.ovr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1;
            rv.clr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1;
            if (rv.clr_at >= 0) rv.e_ovr = (rv.ovr_at >= rv.clr_at);
            else                rv.e_ovr = m_ovr | (rv.ovr_at >= 0);
            run_seq(rv, "rnd");
        end

        // Periodic trigger: period_ms=2 gives one sequence every 2*33 cycles
        M_HREADY = 1'b1; M_HRDATA = 32'h0000_0042;
        @(negedge HCLK);
        enable = 1'b1; period_ms = 16'd2;
        pb = busy;
        for (int t = 0; t < 300; t++) begin
            @(negedge HCLK);
            if (busy && !pb) rises.push_back(t);
            pb = busy;
        end
        chk("period_rise_count_ge3", 32'(rises.size() >= 3), 32'h1);
        for (int k = 1; k < rises.size(); k++)
            chk("period_interval", 32'(rises[k] - rises[k-1]), 32'd66);

        // period_ms=0 must stop periodic triggers
        period_ms = 16'd0;
        repeat (20) @(negedge HCLK);
        cnt = 0; pb = busy;
        for (int t = 0; t < 200; t++) begin
            @(negedge HCLK);
            if (busy && !pb) cnt++;
            pb = busy;
        end
        chk("period_zero_no_trigger", 32'(cnt), 32'd0);

        // enable dropped mid-sequence: sequence completes, then no more triggers
        period_ms = 16'd1;
        cnt = 0;
        for (int t = 0; t < 100 && !busy; t++) @(negedge HCLK);
        chk("enable_seq_started", 32'(busy), 32'h1);
        enable = 1'b0;
        for (int t = 0; t < 20 && cnt == 0; t++) begin
            @(negedge HCLK);
            if (snap_valid) cnt = 1;
        end
        chk("enable_drop_completes", 32'(cnt), 32'h1);
        cnt = 0; pb = busy;
        for (int t = 0; t < 150; t++) begin
            @(negedge HCLK);
            if (busy && !pb) cnt++;
            pb = busy;
        end
        chk("enable_drop_no_trigger", 32'(cnt), 32'd0);

        // Reset during the data phase of 0x0C abandons the sequence
        period_ms = 16'd0;
        M_HRDATA = 32'h1234_5678; M_HREADY = 1'b1;
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        repeat (7) @(negedge HCLK);
        chk("rstmid_pre_fork", dut_snap(0), 32'h5678);
        chk("rstmid_pre_haddr_idle", 32'(M_HTRANS), 32'h0);
        chk("rstmid_pre_busy", 32'(busy), 32'h1);
        M_HREADY = 1'b0;
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0; M_HREADY = 1'b1;
        chk("rstmid_htrans", 32'(M_HTRANS), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_valid", 32'(snap_valid), 32'h0);
        for (int i = 0; i < 5; i++) chk("rstmid_snap", dut_snap(i), 32'h0);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge HCLK);
            if (snap_valid || busy) cnt++;
        end
        chk("rstmid_no_resume", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
